// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle EX occupancy
// and taken-branch flushes for the 5-stage core.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal flow; LU and EX_MulStart are evaluated here
//   LDSTALL | extra load-use bubble cycles after the first, cnt counts down
//   MULBUSY | EX held by a multiply/divide, cnt counts down to MulDone
module hazard_ctrl #(
   parameter int LOAD_STALLS = 1,
   parameter int MUL_LAT     = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_UsesRs,
   input  logic        ID_UsesRt,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic        EX_MulStart,
   input  logic        MEM_BranchTaken,
   output logic        PCWrite,
   output logic        IFID_Write,
   output logic        IFID_Flush,
   output logic        IDEX_Write,
   output logic        IDEX_Bubble,
   output logic        EXMEM_Bubble,
   output logic        MulDone,
   output logic [31:0] StallCycles
);

   typedef enum logic [1:0] {RUN, LDSTALL, MULBUSY} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       lu;

   assign lu = EX_MemRead & (EX_rt != 5'd0) &
               ((ID_UsesRs & (ID_rs == EX_rt)) | (ID_UsesRt & (ID_rt == EX_rt)));

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= RUN;
         cnt         <= 4'd0;
         StallCycles <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!PCWrite && (StallCycles != 32'hFFFF_FFFF))
            StallCycles <= StallCycles + 32'd1;
      end
   end

   always_comb begin
      PCWrite      = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_Write   = 1'b1;
      IDEX_Bubble  = 1'b0;
      EXMEM_Bubble = 1'b0;
      MulDone      = 1'b0;
      state_nxt    = state;
      cnt_nxt      = cnt;

      if (Rst) begin
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         IFID_Flush   = 1'b1;
         IDEX_Bubble  = 1'b1;
         EXMEM_Bubble = 1'b1;
         state_nxt    = RUN;
         cnt_nxt      = 4'd0;
      end else if (MEM_BranchTaken) begin
         // A taken branch squashes everything younger, including any stall.
         IFID_Flush   = 1'b1;
         IDEX_Bubble  = 1'b1;
         EXMEM_Bubble = 1'b1;
         state_nxt    = RUN;
         cnt_nxt      = 4'd0;
      end else begin
         case (state)
            MULBUSY: begin
               PCWrite      = 1'b0;
               IFID_Write   = 1'b0;
               IDEX_Write   = 1'b0;
               EXMEM_Bubble = 1'b1;
               cnt_nxt      = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  MulDone   = 1'b1;
                  state_nxt = RUN;
               end
            end
            LDSTALL: begin
               PCWrite     = 1'b0;
               IFID_Write  = 1'b0;
               IDEX_Bubble = 1'b1;
               cnt_nxt     = cnt - 4'd1;
               if (cnt == 4'd1)
                  state_nxt = RUN;
            end
            RUN: begin
               if (EX_MulStart) begin
                  PCWrite      = 1'b0;
                  IFID_Write   = 1'b0;
                  IDEX_Write   = 1'b0;
                  EXMEM_Bubble = 1'b1;
                  state_nxt    = MULBUSY;
                  cnt_nxt      = 4'(MUL_LAT - 1);
               end else if (lu) begin
                  PCWrite     = 1'b0;
                  IFID_Write  = 1'b0;
                  IDEX_Bubble = 1'b1;
                  if (LOAD_STALLS > 1) begin
                     state_nxt = LDSTALL;
                     cnt_nxt   = 4'(LOAD_STALLS - 1);
                  end
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_STALLS=1 and one with
// LOAD_STALLS=3 share the same stimulus; output vectors are hand-computed.
module tb_hazard_ctrl;

   // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MulDone}
   localparam logic [6:0] NORM  = 7'b1101000;
   localparam logic [6:0] LUO   = 7'b0001100;
   localparam logic [6:0] MULO  = 7'b0000010;
   localparam logic [6:0] MULD  = 7'b0000011;
   localparam logic [6:0] BRO   = 7'b1111110;
   localparam logic [6:0] RSTO  = 7'b0011110;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [4:0]  ID_rs, ID_rt, EX_rt;
   logic        ID_UsesRs, ID_UsesRt, EX_MemRead, EX_MulStart, MEM_BranchTaken;

   logic        pcw1, ifw1, iff1, idw1, idb1, exb1, md1;
   logic        pcw3, ifw3, iff3, idw3, idb3, exb3, md3;
   logic [31:0] sc1, sc3;
   logic [6:0]  o1, o3;

   int checks = 0;
   int passes = 0;

   assign o1 = {pcw1, ifw1, iff1, idw1, idb1, exb1, md1};
   assign o3 = {pcw3, ifw3, iff3, idw3, idb3, exb3, md3};

   always #5 Clk = ~Clk;

   hazard_ctrl #(.LOAD_STALLS(1), .MUL_LAT(4)) dut1 (
      .Clk(Clk), .Rst(Rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
      .EX_rt(EX_rt), .EX_MulStart(EX_MulStart), .MEM_BranchTaken(MEM_BranchTaken),
      .PCWrite(pcw1), .IFID_Write(ifw1), .IFID_Flush(iff1), .IDEX_Write(idw1),
      .IDEX_Bubble(idb1), .EXMEM_Bubble(exb1), .MulDone(md1), .StallCycles(sc1)
   );

   hazard_ctrl #(.LOAD_STALLS(3), .MUL_LAT(4)) dut3 (
      .Clk(Clk), .Rst(Rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
      .EX_rt(EX_rt), .EX_MulStart(EX_MulStart), .MEM_BranchTaken(MEM_BranchTaken),
      .PCWrite(pcw3), .IFID_Write(ifw3), .IFID_Flush(iff3), .IDEX_Write(idw3),
      .IDEX_Bubble(idb3), .EXMEM_Bubble(exb3), .MulDone(md3), .StallCycles(sc3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
      ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; EX_MemRead = 1'b0;
      EX_MulStart = 1'b0; MEM_BranchTaken = 1'b0;
      #1;
   endtask

   task automatic both(input string tag, input logic [6:0] e1, input logic [6:0] e3);
      check({tag, "_o1"}, 32'(o1), 32'(e1));
      check({tag, "_o3"}, 32'(o3), 32'(e3));
   endtask

   task automatic counts(input string tag, input int e1, input int e3);
      check({tag, "_sc1"}, sc1, 32'(e1));
      check({tag, "_sc3"}, sc3, 32'(e3));
   endtask

   initial begin
      Rst = 1'b1;
      idle();
      cyc();
      both("rst", RSTO, RSTO);
      counts("rst", 0, 0);
      Rst = 1'b0;
      #1;
      both("run0", NORM, NORM);

      // Load-use on rs
      EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_UsesRs = 1'b1;
      #1;
      both("lu_rs_c0", LUO, LUO);
      cyc(); idle();
      both("lu_rs_c1", NORM, LUO);
      counts("lu_rs_c1", 1, 1);
      cyc();
      both("lu_rs_c2", NORM, LUO);
      cyc();
      both("lu_rs_c3", NORM, NORM);
      counts("lu_rs_c3", 1, 3);

      // Load-use on rt
      EX_MemRead = 1'b1; EX_rt = 5'd8; ID_rt = 5'd8; ID_UsesRt = 1'b1;
      #1;
      both("lu_rt_c0", LUO, LUO);
      cyc(); idle();
      both("lu_rt_c1", NORM, LUO);
      cyc();
      both("lu_rt_c2", NORM, LUO);
      cyc();
      both("lu_rt_c3", NORM, NORM);
      counts("lu_rt_c3", 2, 6);

      // Non-hazards: r0 destination, register mismatch, source not used
      EX_MemRead = 1'b1; EX_rt = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b1;
      #1;
      both("lu_r0", NORM, NORM);
      cyc();
      EX_rt = 5'd8; ID_rt = 5'd9;
      #1;
      both("lu_mismatch", NORM, NORM);
      cyc();
      ID_rt = 5'd8; ID_UsesRt = 1'b0;
      #1;
      both("lu_unused", NORM, NORM);
      cyc(); idle();
      both("nohz_after", NORM, NORM);
      counts("nohz", 2, 6);

      // Multiply, MUL_LAT=4
      EX_MulStart = 1'b1;
      #1;
      both("mul_c0", MULO, MULO);
      cyc(); idle();
      both("mul_c1", MULO, MULO);
      cyc();
      both("mul_c2", MULO, MULO);
      cyc();
      both("mul_c3", MULD, MULD);
      cyc();
      both("mul_c4", NORM, NORM);
      counts("mul", 6, 10);

      // Branch in the 2nd busy cycle aborts the multiply
      EX_MulStart = 1'b1;
      #1;
      both("brm_c0", MULO, MULO);
      cyc(); idle();
      MEM_BranchTaken = 1'b1;
      #1;
      both("brm_c1", BRO, BRO);
      cyc(); idle();
      both("brm_c2", NORM, NORM);
      cyc();
      both("brm_c3", NORM, NORM);
      cyc();
      both("brm_c4", NORM, NORM);
      counts("brm", 7, 11);

      // Simultaneous multiply start and load-use; inputs held through busy cycles
      EX_MulStart = 1'b1; EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_UsesRs = 1'b1;
      #1;
      both("mlu_c0", MULO, MULO);
      cyc();
      both("mlu_c1", MULO, MULO);
      cyc();
      both("mlu_c2", MULO, MULO);
      cyc();
      both("mlu_c3", MULD, MULD);
      cyc(); idle();
      both("mlu_c4", NORM, NORM);
      counts("mlu", 11, 15);

      // Reset in the middle of an LDSTALL
      EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_UsesRs = 1'b1;
      #1;
      both("rld_c0", LUO, LUO);
      cyc(); idle();
      both("rld_c1", NORM, LUO);
      counts("rld_c1", 12, 16);
      cyc();
      Rst = 1'b1;
      #1;
      both("rld_rst", RSTO, RSTO);
      cyc();
      Rst = 1'b0;
      #1;
      both("rld_after", NORM, NORM);
      counts("rld_after", 0, 0);
      cyc();
      both("rld_after2", NORM, NORM);
      counts("rld_after2", 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
